systolic_skew_feeder: RTL and testbench

Parametrised activation feeder for an N-row systolic array. It accepts a full N×K activation matrix in one handshake and streams it row-skewed: row r is delayed r cycles and zero-padded, so each PE row sees its operands diagonally aligned. A shadow buffer accepts the next matrix while the current one streams, so consecutive matrices issue back-to-back without bubbles. An `advance` input lets the array controller freeze the stream.

---
 rtl/systolic_skew_feeder_if.sv | 24 ++
 rtl/systolic_skew_feeder.sv | 93 +++++++++
 tb/tb_systolic_skew_feeder.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/systolic_skew_feeder_if.sv
// systolic_skew_feeder_if: load handshake, stream control and skewed output bundle for the feeder.
// SKEW_FEEDER_ROW_VALID_EN adds the per-lane row_valid flags.
interface systolic_skew_feeder_if #(
    parameter int DATA_W = 8,
    parameter int N = 2,
    parameter int K = 2
);
    logic                    load_valid;
    logic                    load_ready;
    logic [N*K*DATA_W-1:0]   a_flat;
    logic                    advance;
    logic [N*DATA_W-1:0]     a_out;
    logic                    out_valid;
    logic                    done;
    logic                    busy;
`ifdef SKEW_FEEDER_ROW_VALID_EN
    logic [N-1:0]            row_valid;
    modport master(output load_valid, a_flat, advance, input load_ready, a_out, out_valid, done, busy, row_valid);
    modport slave(input load_valid, a_flat, advance, output load_ready, a_out, out_valid, done, busy, row_valid);
`else
    modport master(output load_valid, a_flat, advance, input load_ready, a_out, out_valid, done, busy);
    modport slave(input load_valid, a_flat, advance, output load_ready, a_out, out_valid, done, busy);
`endif
endinterface

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: streams an N x K activation matrix row-skewed, with a shadow buffer for bubble-free back-to-back matrices.
// Optional macro SKEW_FEEDER_ROW_VALID_EN adds registered per-lane real-element flags.
module systolic_skew_feeder #(
    parameter int DATA_W = 8,
    parameter int N = 2,
    parameter int K = 2
) (
    input logic clk,
    input logic reset,
    systolic_skew_feeder_if.slave bus
);
    localparam int L = K + N - 1;
    localparam int CW = $clog2(K + N);
    localparam logic [CW-1:0] LAST = CW'(L - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                          state_q;
    logic [N-1:0][K-1:0][DATA_W-1:0] shadow_q, active_q;
    logic                            shadow_full_q, out_valid_q, done_q;
    logic [CW-1:0]                   cnt_q;
    logic [N-1:0][DATA_W-1:0]        a_out_q, lane_d;
    logic                            load_ready, beat, last_beat;
`ifdef SKEW_FEEDER_ROW_VALID_EN
    logic [N-1:0]                    row_ok_d, row_valid_q;
    assign bus.row_valid = row_valid_q;
`endif

    assign load_ready    = !shadow_full_q && !reset;
    assign beat          = state_q == STREAM && bus.advance;
    assign last_beat     = beat && cnt_q == LAST;
    assign bus.load_ready = load_ready;
    assign bus.a_out     = a_out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.done      = done_q;
    assign bus.busy      = state_q == STREAM || shadow_full_q;

    // Lane r shows element cnt-r of its row; outside 0..K-1 it is zero padding.
    always_comb begin
        lane_d = '0;
`ifdef SKEW_FEEDER_ROW_VALID_EN
        row_ok_d = '0;
`endif
        for (int r = 0; r < N; r++) begin
            for (int k = 0; k < K; k++) begin
                if (int'(cnt_q) == r + k) begin
                    lane_d[r] = active_q[r][k];
`ifdef SKEW_FEEDER_ROW_VALID_EN
                    row_ok_d[r] = 1'b1;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            shadow_q      <= '0;
            active_q      <= '0;
            shadow_full_q <= 1'b0;
            cnt_q         <= '0;
            a_out_q       <= '0;
            out_valid_q   <= 1'b0;
            done_q        <= 1'b0;
`ifdef SKEW_FEEDER_ROW_VALID_EN
            row_valid_q   <= '0;
`endif
        end else begin
            if (bus.load_valid && load_ready) begin
                shadow_q      <= bus.a_flat;
                shadow_full_q <= 1'b1;
            end
            a_out_q     <= beat ? lane_d : '0;
            out_valid_q <= beat;
            done_q      <= last_beat;
`ifdef SKEW_FEEDER_ROW_VALID_EN
            row_valid_q <= beat ? row_ok_d : '0;
`endif
            // Load and transfer are exclusive: load needs an empty shadow, transfer a full one.
            if ((state_q == IDLE || last_beat) && shadow_full_q) begin
                active_q      <= shadow_q;
                shadow_full_q <= 1'b0;
                cnt_q         <= '0;
                state_q       <= STREAM;
            end else if (last_beat) begin
                state_q <= IDLE;
            end else if (beat) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb_systolic_skew_feeder: vector table and corner sequences on a 2x2 feeder, randomized model check on a 3x4 feeder.
module tb_systolic_skew_feeder;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    systolic_skew_feeder_if #(.DATA_W(DW), .N(2), .K(2)) b1 ();
    systolic_skew_feeder_if #(.DATA_W(DW), .N(3), .K(4)) b2 ();

    systolic_skew_feeder #(.DATA_W(DW), .N(2), .K(2)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));
    systolic_skew_feeder #(.DATA_W(DW), .N(3), .K(4)) dut2 (.clk(clk), .reset(reset), .bus(b2.slave));

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic        adv;
        logic [15:0] a_out;
        logic        ov;
        logic        done;
        logic        busy;
        logic        rdy;
        logic [1:0]  rv;
    } vec_t;

    typedef struct {
        logic [23:0] a_out;
        logic        done;
    } beat_t;

    vec_t        tbl[8];
    beat_t       exp_q[$];
    beat_t       e;
    logic [15:0] b2b_out[6];
    logic        b2b_done[6];
    logic [95:0] m;
    logic        acc, adv;
    int          offered;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected beats come straight from the skew rule: beat b, lane r carries element (r, b-r) when it exists.
    task automatic push_beats(input logic [95:0] mat);
        beat_t bt;
        for (int b = 0; b < 6; b++) begin
            bt.a_out = '0;
            for (int r = 0; r < 3; r++) begin
                if (b - r >= 0 && b - r < 4) bt.a_out[r*8 +: 8] = mat[(r*4 + b - r)*8 +: 8];
            end
            bt.done = (b == 5);
            exp_q.push_back(bt);
        end
    endtask

    initial begin
        tbl[0] = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
        tbl[1] = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00};
        tbl[2] = '{1'b1, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01};
        tbl[3] = '{1'b1, 16'h0302, 1'b1, 1'b0, 1'b1, 1'b1, 2'b11};
        tbl[4] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00};
        tbl[5] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00};
        tbl[6] = '{1'b1, 16'h0400, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10};
        tbl[7] = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00};
        b2b_out  = '{16'h0001, 16'h0302, 16'h0400, 16'h0005, 16'h0706, 16'h0800};
        b2b_done = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        b1.load_valid = 1'b0; b1.a_flat = '0; b1.advance = 1'b0;
        b2.load_valid = 1'b0; b2.a_flat = '0; b2.advance = 1'b0;

        step(); step();
        chk("rst_out_valid", b1.out_valid, 0);
        chk("rst_a_out", b1.a_out, 0);
        chk("rst_done", b1.done, 0);
        chk("rst_busy", b1.busy, 0);
        chk("rst_ready_low", b1.load_ready, 0);
        reset = 1'b0;
        #1;
        chk("ready_after_rst", b1.load_ready, 1);

        // Single matrix A with a two-cycle stall after beat 1.
        b1.a_flat = 32'h04030201;
        for (int i = 0; i < 8; i++) begin
            b1.load_valid = (i == 0);
            b1.advance = tbl[i].adv;
            step();
            chk($sformatf("tbl%0d_a_out", i), b1.a_out, tbl[i].a_out);
            chk($sformatf("tbl%0d_out_valid", i), b1.out_valid, tbl[i].ov);
            chk($sformatf("tbl%0d_done", i), b1.done, tbl[i].done);
            chk($sformatf("tbl%0d_busy", i), b1.busy, tbl[i].busy);
            chk($sformatf("tbl%0d_ready", i), b1.load_ready, tbl[i].rdy);
`ifdef SKEW_FEEDER_ROW_VALID_EN
            chk($sformatf("tbl%0d_row_valid", i), b1.row_valid, tbl[i].rv);
`endif
        end

        // Back-to-back A then B: no bubble between matrices.
        b1.advance = 1'b1;
        b1.load_valid = 1'b1;
        b1.a_flat = 32'h04030201;
        step();
        b1.a_flat = 32'h08070605;
        step();
        chk("b2b_ready_reopens", b1.load_ready, 1);
        for (int i = 0; i < 6; i++) begin
            step();
            b1.load_valid = 1'b0;
            chk($sformatf("b2b%0d_a_out", i), b1.a_out, b2b_out[i]);
            chk($sformatf("b2b%0d_out_valid", i), b1.out_valid, 1);
            chk($sformatf("b2b%0d_done", i), b1.done, b2b_done[i]);
            chk($sformatf("b2b%0d_ready", i), b1.load_ready, i >= 2);
        end
        step();
        chk("b2b_end_quiet", b1.out_valid, 0);

        // Reset mid-stream while B sits in the shadow.
        b1.load_valid = 1'b1;
        b1.a_flat = 32'h04030201;
        step();
        b1.a_flat = 32'h08070605;
        step();
        step();
        b1.load_valid = 1'b0;
        step();
        chk("pre_rst_streaming", b1.out_valid, 1);
        reset = 1'b1;
        step();
        chk("midrst_out_valid", b1.out_valid, 0);
        chk("midrst_a_out", b1.a_out, 0);
        chk("midrst_busy", b1.busy, 0);
        chk("midrst_ready_low", b1.load_ready, 0);
        reset = 1'b0;
        #1;
        chk("midrst_ready_after", b1.load_ready, 1);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("midrst_no_beats", {b1.out_valid, b1.a_out}, 0);
        end

        // 3x4 feeder: fixed 1..12 matrix first, then random matrices and random stalls.
        offered = 0;
        for (int cyc = 0; cyc < 1500 && (offered < 20 || exp_q.size() > 0 || b2.load_valid); cyc++) begin
            if (!b2.load_valid && offered < 20 && $urandom_range(0, 2) == 0) begin
                if (offered == 0) begin
                    for (int j = 0; j < 12; j++) m[j*8 +: 8] = 8'(j + 1);
                end else begin
                    m = {$urandom, $urandom, $urandom};
                end
                b2.a_flat = m;
                b2.load_valid = 1'b1;
                push_beats(m);
                offered++;
            end
            b2.advance = (offered >= 20) ? 1'b1 : ($urandom_range(0, 3) != 0);
            acc = b2.load_valid && b2.load_ready;
            adv = b2.advance;
            step();
            if (acc) b2.load_valid = 1'b0;
            if (!adv) chk("rnd_stall_quiet", b2.out_valid, 0);
            if (b2.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_extra_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rnd_a_out", b2.a_out, e.a_out);
                    chk("rnd_done", b2.done, e.done);
                end
            end else begin
                chk("rnd_idle_zero", {b2.a_out, b2.done}, 0);
            end
        end
        chk("rnd_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
